// File: rtl/reorder_buffer_mc_if.sv
// Bundle of the dispatch, CDB, commit, flush and operand-query signals around the reorder buffer.
// The pipeline (decode, execute, register file) drives through master; the ROB uses slave.
interface reorder_buffer_mc_if #(
    parameter int ROB_ENTRIES    = 16,
    parameter int ROB_ADDR_WIDTH = $clog2(ROB_ENTRIES),
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 4,
    parameter int CDB_PORTS      = 2,
    parameter int COMMIT_WIDTH   = 2
);
    logic                                  dispatch_valid;
    logic [4:0]                            dispatch_dest_reg;
    logic                                  dispatch_dest_valid;
    logic                                  dispatch_ready;
    logic [ROB_ADDR_WIDTH-1:0]             dispatch_rob_tag;

    logic [CDB_PORTS-1:0]                  cdb_valid;
    logic [CDB_PORTS*ROB_ADDR_WIDTH-1:0]   cdb_tag;
    logic [CDB_PORTS*DATA_WIDTH-1:0]       cdb_data;
    logic [CDB_PORTS-1:0]                  cdb_mispredict;
    logic [CDB_PORTS*PC_WIDTH-1:0]         cdb_target_pc;

    logic [COMMIT_WIDTH-1:0]               commit_valid;
    logic [COMMIT_WIDTH*5-1:0]             commit_dest_reg;
    logic [COMMIT_WIDTH*DATA_WIDTH-1:0]    commit_value;
    logic [COMMIT_WIDTH-1:0]               commit_reg_write;
    logic [COMMIT_WIDTH*ROB_ADDR_WIDTH-1:0] commit_rob_tag;

    logic                                  flush;
    logic [PC_WIDTH-1:0]                   flush_pc;

    logic [2*ROB_ADDR_WIDTH-1:0]           query_tag;
    logic [1:0]                            query_ready;
    logic [2*DATA_WIDTH-1:0]               query_value;

    logic [ROB_ADDR_WIDTH:0]               rob_count;

    modport master (
        output dispatch_valid, dispatch_dest_reg, dispatch_dest_valid,
        input  dispatch_ready, dispatch_rob_tag,
        output cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target_pc,
        input  commit_valid, commit_dest_reg, commit_value, commit_reg_write, commit_rob_tag,
        input  flush, flush_pc,
        output query_tag,
        input  query_ready, query_value,
        input  rob_count
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_reg, dispatch_dest_valid,
        output dispatch_ready, dispatch_rob_tag,
        input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target_pc,
        output commit_valid, commit_dest_reg, commit_value, commit_reg_write, commit_rob_tag,
        output flush, flush_pc,
        input  query_tag,
        output query_ready, query_value,
        output rob_count
    );
endinterface

// File: rtl/reorder_buffer_mc.sv
// Multi-port, multi-commit reorder buffer with mispredict flush and forwarding operand queries.
// Head/tail carry an extra wrap bit so a full buffer is distinguishable from an empty one.
module reorder_buffer_mc #(
    parameter int ROB_ENTRIES    = 16,
    parameter int ROB_ADDR_WIDTH = $clog2(ROB_ENTRIES),
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 4,
    parameter int CDB_PORTS      = 2,
    parameter int COMMIT_WIDTH   = 2
) (
    input  logic               clock,
    input  logic               reset,
    reorder_buffer_mc_if.slave rob_if
);
    localparam int AW = ROB_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = PC_WIDTH;

    logic [ROB_ENTRIES-1:0] valid_q;
    logic [ROB_ENTRIES-1:0] done_q;
    logic [ROB_ENTRIES-1:0] reg_write_q;
    logic [ROB_ENTRIES-1:0] mispredict_q;
    logic [4:0]             dest_reg_q  [ROB_ENTRIES];
    logic [DW-1:0]          value_q     [ROB_ENTRIES];
    logic [PW-1:0]          target_pc_q [ROB_ENTRIES];

    logic [AW:0]            head_q;
    logic [AW:0]            tail_q;
    logic [AW:0]            count;
    logic                   full;
    logic                   dispatch_fire;

    logic [AW-1:0]          cdb_tag_u  [CDB_PORTS];
    logic [DW-1:0]          cdb_data_u [CDB_PORTS];
    logic [PW-1:0]          cdb_pc_u   [CDB_PORTS];

    logic [COMMIT_WIDTH-1:0]      slot_valid;
    logic [AW:0]                  commit_num;
    logic                         flush;
    logic [PW-1:0]                flush_pc;
    logic [COMMIT_WIDTH*5-1:0]    commit_dest_reg;
    logic [COMMIT_WIDTH*DW-1:0]   commit_value;
    logic [COMMIT_WIDTH-1:0]      commit_reg_write;
    logic [COMMIT_WIDTH*AW-1:0]   commit_rob_tag;
    logic [1:0]                   query_ready;
    logic [2*DW-1:0]              query_value;

    assign count         = tail_q - head_q;
    assign full          = (count == (AW+1)'(ROB_ENTRIES));
    assign dispatch_fire = rob_if.dispatch_valid && !full && !flush;

    always_comb begin
        for (int i = 0; i < CDB_PORTS; i++) begin
            cdb_tag_u[i]  = rob_if.cdb_tag[i*AW +: AW];
            cdb_data_u[i] = rob_if.cdb_data[i*DW +: DW];
            cdb_pc_u[i]   = rob_if.cdb_target_pc[i*PW +: PW];
        end
    end

    // Retire a contiguous run of done entries from head; a mispredicting entry retires but ends the group.
    always_comb begin
        logic          chain;
        logic [AW-1:0] idx;
        slot_valid       = '0;
        commit_num       = '0;
        flush            = 1'b0;
        flush_pc         = '0;
        commit_dest_reg  = '0;
        commit_value     = '0;
        commit_reg_write = '0;
        commit_rob_tag   = '0;
        chain            = 1'b1;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            idx = head_q[AW-1:0] + AW'(j);
            commit_dest_reg[j*5 +: 5]  = dest_reg_q[idx];
            commit_value[j*DW +: DW]   = value_q[idx];
            commit_rob_tag[j*AW +: AW] = idx;
            if (chain && valid_q[idx] && done_q[idx]) begin
                slot_valid[j]       = 1'b1;
                commit_reg_write[j] = reg_write_q[idx];
                commit_num          = commit_num + 1'b1;
                if (mispredict_q[idx]) begin
                    flush    = 1'b1;
                    flush_pc = target_pc_q[idx];
                    chain    = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Operand lookup: a same-cycle CDB hit beats the stored entry, highest port index last.
    always_comb begin
        logic [AW-1:0] qt;
        query_ready = '0;
        query_value = '0;
        for (int k = 0; k < 2; k++) begin
            qt = rob_if.query_tag[k*AW +: AW];
            query_ready[k] = valid_q[qt] && done_q[qt];
            query_value[k*DW +: DW] = valid_q[qt] ? value_q[qt] : '0;
            for (int i = 0; i < CDB_PORTS; i++) begin
                if (rob_if.cdb_valid[i] && (cdb_tag_u[i] == qt)) begin
                    query_ready[k] = 1'b1;
                    query_value[k*DW +: DW] = cdb_data_u[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            reg_write_q  <= '0;
            mispredict_q <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                dest_reg_q[e]  <= '0;
                value_q[e]     <= '0;
                target_pc_q[e] <= '0;
            end
        end else if (flush) begin
            // Everything younger than the mispredict is discarded, so the buffer simply empties.
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= tail_q;
        end else begin
            head_q <= head_q + commit_num;
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (slot_valid[j]) begin
                    valid_q[head_q[AW-1:0] + AW'(j)] <= 1'b0;
                end
            end
            if (dispatch_fire) begin
                valid_q[tail_q[AW-1:0]]      <= 1'b1;
                done_q[tail_q[AW-1:0]]       <= 1'b0;
                mispredict_q[tail_q[AW-1:0]] <= 1'b0;
                dest_reg_q[tail_q[AW-1:0]]   <= rob_if.dispatch_dest_reg;
                reg_write_q[tail_q[AW-1:0]]  <= rob_if.dispatch_dest_valid &&
                                                (rob_if.dispatch_dest_reg != 5'd0);
                tail_q <= tail_q + 1'b1;
            end
            for (int i = 0; i < CDB_PORTS; i++) begin
                if (rob_if.cdb_valid[i] && valid_q[cdb_tag_u[i]] && !done_q[cdb_tag_u[i]]) begin
                    done_q[cdb_tag_u[i]]       <= 1'b1;
                    value_q[cdb_tag_u[i]]      <= cdb_data_u[i];
                    mispredict_q[cdb_tag_u[i]] <= rob_if.cdb_mispredict[i];
                    target_pc_q[cdb_tag_u[i]]  <= cdb_pc_u[i];
                end
            end
        end
    end

    assign rob_if.dispatch_ready   = !full;
    assign rob_if.dispatch_rob_tag = tail_q[AW-1:0];
    assign rob_if.commit_valid     = slot_valid;
    assign rob_if.commit_dest_reg  = commit_dest_reg;
    assign rob_if.commit_value     = commit_value;
    assign rob_if.commit_reg_write = commit_reg_write;
    assign rob_if.commit_rob_tag   = commit_rob_tag;
    assign rob_if.flush            = flush;
    assign rob_if.flush_pc         = flush_pc;
    assign rob_if.query_ready      = query_ready;
    assign rob_if.query_value      = query_value;
    assign rob_if.rob_count        = count;
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: a per-cycle vector table for basic in-order retirement,
// then hand-written sequences for full/wrap, mispredict flush, forwarding and mid-run reset.
module tb_reorder_buffer_mc;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;

    reorder_buffer_mc_if #(
        .ROB_ENTRIES(16), .ROB_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PC_WIDTH(4), .CDB_PORTS(2), .COMMIT_WIDTH(2)
    ) rob_if ();

    reorder_buffer_mc #(
        .ROB_ENTRIES(16), .ROB_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .PC_WIDTH(4), .CDB_PORTS(2), .COMMIT_WIDTH(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rob_if(rob_if)
    );

    typedef struct {
        logic        d_valid;
        logic [4:0]  d_reg;
        logic [1:0]  c_valid;
        logic [3:0]  c_tag0;
        logic [3:0]  c_tag1;
        logic [31:0] c_data0;
        logic [31:0] c_data1;
        logic [3:0]  q_tag0;
        logic        e_ready;
        logic [3:0]  e_tag;
        logic [4:0]  e_count;
        logic [1:0]  e_cvalid;
        logic [3:0]  e_ctag0;
        logic [3:0]  e_ctag1;
        logic [31:0] e_cval0;
        logic [31:0] e_cval1;
        logic [1:0]  e_cregw;
        logic        e_qready0;
        logic [31:0] e_qval0;
    } vec_t;

    vec_t vecs [8];

    task automatic applyStimulus(input logic dv, input logic [4:0] dreg,
                                 input logic [1:0] cv, input logic [3:0] t0, input logic [31:0] d0,
                                 input logic [3:0] t1, input logic [31:0] d1,
                                 input logic [1:0] mp, input logic [3:0] pc1,
                                 input logic [3:0] q0, input logic [3:0] q1);
        rob_if.dispatch_valid      = dv;
        rob_if.dispatch_dest_reg   = dreg;
        rob_if.dispatch_dest_valid = dv;
        rob_if.cdb_valid           = cv;
        rob_if.cdb_tag             = {t1, t0};
        rob_if.cdb_data            = {d1, d0};
        rob_if.cdb_mispredict      = mp;
        rob_if.cdb_target_pc       = {pc1, 4'h0};
        rob_if.query_tag           = {q1, q0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic dispatchOne(input logic [4:0] dreg);
        @(negedge clock);
        applyStimulus(1'b1, dreg, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
    endtask

    initial begin
        // d_valid d_reg c_valid c_tag0 c_tag1 c_data0 c_data1 q_tag0 | ready tag count cvalid ctag0 ctag1 cval0 cval1 cregw qready0 qval0
        vecs[0] = '{1'b1, 5'd5, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd0, 1'b1, 4'd0, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 5'd6, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd0, 1'b1, 4'd1, 5'd1, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd0, 1'b1, 4'd2, 5'd2, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 2'b01, 4'd1, 4'd0, 32'h11, 32'h0,  4'd1, 1'b1, 4'd3, 5'd3, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b1, 32'h11};
        vecs[4] = '{1'b0, 5'd0, 2'b11, 4'd0, 4'd2, 32'h10, 32'h22, 4'd1, 1'b1, 4'd3, 5'd3, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b1, 32'h11};
        vecs[5] = '{1'b0, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd0, 1'b1, 4'd3, 5'd3, 2'b11, 4'd0, 4'd1, 32'h10, 32'h11, 2'b11, 1'b1, 32'h10};
        vecs[6] = '{1'b0, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd2, 1'b1, 4'd3, 5'd1, 2'b01, 4'd2, 4'd0, 32'h22, 32'h0,  2'b00, 1'b1, 32'h22};
        vecs[7] = '{1'b0, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd2, 1'b1, 4'd3, 5'd0, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  2'b00, 1'b0, 32'h0};

        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("reset count", 32'(rob_if.rob_count), 32'd0);
        checkOutput("reset dispatch_ready", 32'(rob_if.dispatch_ready), 32'd1);
        checkOutput("reset dispatch_rob_tag", 32'(rob_if.dispatch_rob_tag), 32'd0);
        checkOutput("reset commit_valid", 32'(rob_if.commit_valid), 32'd0);
        checkOutput("reset flush", 32'(rob_if.flush), 32'd0);
        checkOutput("reset flush_pc", 32'(rob_if.flush_pc), 32'd0);
        checkOutput("reset query_ready", 32'(rob_if.query_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Table: dispatch x5/x6/x0, out-of-order completion, two-wide then single retirement.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i].d_valid, vecs[i].d_reg, vecs[i].c_valid, vecs[i].c_tag0, vecs[i].c_data0,
                          vecs[i].c_tag1, vecs[i].c_data1, 2'b00, 4'd0, vecs[i].q_tag0, 4'd0);
            #1;
            checkOutput($sformatf("vec%0d dispatch_ready", i), 32'(rob_if.dispatch_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("vec%0d dispatch_rob_tag", i), 32'(rob_if.dispatch_rob_tag), 32'(vecs[i].e_tag));
            checkOutput($sformatf("vec%0d rob_count", i), 32'(rob_if.rob_count), 32'(vecs[i].e_count));
            checkOutput($sformatf("vec%0d commit_valid", i), 32'(rob_if.commit_valid), 32'(vecs[i].e_cvalid));
            checkOutput($sformatf("vec%0d commit_reg_write", i), 32'(rob_if.commit_reg_write), 32'(vecs[i].e_cregw));
            checkOutput($sformatf("vec%0d query_ready0", i), 32'(rob_if.query_ready[0]), 32'(vecs[i].e_qready0));
            if (vecs[i].e_qready0)
                checkOutput($sformatf("vec%0d query_value0", i), rob_if.query_value[31:0], vecs[i].e_qval0);
            if (vecs[i].e_cvalid[0]) begin
                checkOutput($sformatf("vec%0d commit_tag0", i), 32'(rob_if.commit_rob_tag[3:0]), 32'(vecs[i].e_ctag0));
                checkOutput($sformatf("vec%0d commit_value0", i), rob_if.commit_value[31:0], vecs[i].e_cval0);
            end
            if (vecs[i].e_cvalid[1]) begin
                checkOutput($sformatf("vec%0d commit_tag1", i), 32'(rob_if.commit_rob_tag[7:4]), 32'(vecs[i].e_ctag1));
                checkOutput($sformatf("vec%0d commit_value1", i), rob_if.commit_value[63:32], vecs[i].e_cval1);
            end
        end

        // Fill all 16 entries, refuse a 17th, then drain two per cycle through the wrap.
        doReset();
        for (int i = 0; i < 16; i++) begin
            dispatchOne(5'(i + 1));
            checkOutput($sformatf("fill tag %0d", i), 32'(rob_if.dispatch_rob_tag), 32'(i));
        end
        dispatchOne(5'd20);
        checkOutput("full dispatch_ready", 32'(rob_if.dispatch_ready), 32'd0);
        checkOutput("full rob_count", 32'(rob_if.rob_count), 32'd16);
        idleCycle();
        checkOutput("ignored 17th count", 32'(rob_if.rob_count), 32'd16);
        checkOutput("ignored 17th tag", 32'(rob_if.dispatch_rob_tag), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            applyStimulus(k == 1, 5'd21, 2'b11, 4'(2*k), 32'h100 + 32'(2*k),
                          4'(2*k + 1), 32'h101 + 32'(2*k), 2'b00, 4'd0, 4'd0, 4'd0);
            #1;
            checkOutput($sformatf("drain%0d count", k), 32'(rob_if.rob_count),
                        (k <= 1) ? 32'd16 : 32'(16 - 2*(k - 1)));
            if (k == 1)
                checkOutput("retiring-full dispatch_ready", 32'(rob_if.dispatch_ready), 32'd0);
            if (k > 0) begin
                checkOutput($sformatf("drain%0d commit_valid", k), 32'(rob_if.commit_valid), 32'h3);
                checkOutput($sformatf("drain%0d commit_tag0", k), 32'(rob_if.commit_rob_tag[3:0]), 32'(2*(k - 1)));
                checkOutput($sformatf("drain%0d commit_value1", k), rob_if.commit_value[63:32], 32'h101 + 32'(2*(k - 1)));
            end
        end
        idleCycle();
        checkOutput("drain last commit_valid", 32'(rob_if.commit_valid), 32'h3);
        checkOutput("drain last commit_tag0", 32'(rob_if.commit_rob_tag[3:0]), 32'd14);
        checkOutput("drain last count", 32'(rob_if.rob_count), 32'd2);
        idleCycle();
        checkOutput("drained count", 32'(rob_if.rob_count), 32'd0);
        checkOutput("wrapped tag", 32'(rob_if.dispatch_rob_tag), 32'd0);
        checkOutput("drained commit_valid", 32'(rob_if.commit_valid), 32'd0);

        // Mispredict on tag 1 retires with tag 0 and flushes the younger tags 2 and 3.
        doReset();
        for (int i = 0; i < 4; i++) dispatchOne(5'(i + 1));
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd2, 32'h32, 4'd3, 32'h33, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("pre-flush commit_valid", 32'(rob_if.commit_valid), 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd0, 32'h50, 4'd1, 32'h51, 2'b10, 4'h9, 4'd0, 4'd0);
        #1;
        checkOutput("tag0 alone not done commit_valid", 32'(rob_if.commit_valid), 32'd0);
        @(negedge clock);
        applyStimulus(1'b1, 5'd9, 2'b01, 4'd3, 32'hEE, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("flush", 32'(rob_if.flush), 32'd1);
        checkOutput("flush_pc", 32'(rob_if.flush_pc), 32'h9);
        checkOutput("flush commit_valid", 32'(rob_if.commit_valid), 32'h3);
        checkOutput("flush commit_tag0", 32'(rob_if.commit_rob_tag[3:0]), 32'd0);
        checkOutput("flush commit_tag1", 32'(rob_if.commit_rob_tag[7:4]), 32'd1);
        checkOutput("flush commit_value1", rob_if.commit_value[63:32], 32'h51);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd3, 32'hEE, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("post-flush count", 32'(rob_if.rob_count), 32'd0);
        checkOutput("post-flush flush", 32'(rob_if.flush), 32'd0);
        checkOutput("post-flush commit_valid", 32'(rob_if.commit_valid), 32'd0);
        checkOutput("post-flush tag", 32'(rob_if.dispatch_rob_tag), 32'd4);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd3, 4'd0);
        #1;
        checkOutput("stale tag3 query_ready", 32'(rob_if.query_ready), 32'd0);
        checkOutput("stale commit_valid", 32'(rob_if.commit_valid), 32'd0);

        // Same-cycle forwarding of a CDB result to an operand query.
        dispatchOne(5'd7);
        checkOutput("fwd dispatch tag", 32'(rob_if.dispatch_rob_tag), 32'd4);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b01, 4'd4, 32'hAA, 4'd0, 32'd0, 2'b00, 4'd0, 4'd4, 4'd5);
        #1;
        checkOutput("fwd query_ready", 32'(rob_if.query_ready), 32'h1);
        checkOutput("fwd query_value0", rob_if.query_value[31:0], 32'hAA);
        dispatchOne(5'd8);
        checkOutput("fwd commit_valid", 32'(rob_if.commit_valid), 32'h1);
        checkOutput("fwd commit_tag0", 32'(rob_if.commit_rob_tag[3:0]), 32'd4);
        checkOutput("fwd commit_value0", rob_if.commit_value[31:0], 32'hAA);
        dispatchOne(5'd9);

        // Both ports complete different entries in one cycle; they retire together.
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 2'b11, 4'd6, 32'h66, 4'd5, 32'h55, 2'b00, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("dual wb commit_valid before", 32'(rob_if.commit_valid), 32'd0);
        idleCycle();
        checkOutput("dual commit_valid", 32'(rob_if.commit_valid), 32'h3);
        checkOutput("dual commit_tag0", 32'(rob_if.commit_rob_tag[3:0]), 32'd5);
        checkOutput("dual commit_tag1", 32'(rob_if.commit_rob_tag[7:4]), 32'd6);
        checkOutput("dual commit_value0", rob_if.commit_value[31:0], 32'h55);
        checkOutput("dual commit_value1", rob_if.commit_value[63:32], 32'h66);
        checkOutput("dual commit_reg_write", 32'(rob_if.commit_reg_write), 32'h3);
        checkOutput("dual count", 32'(rob_if.rob_count), 32'd2);

        // Asynchronous reset with live entries empties the buffer without a clock edge.
        idleCycle();
        for (int i = 0; i < 5; i++) dispatchOne(5'(i + 10));
        idleCycle();
        checkOutput("pre-reset count", 32'(rob_if.rob_count), 32'd5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("async reset count", 32'(rob_if.rob_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("after reset tag", 32'(rob_if.dispatch_rob_tag), 32'd0);
        checkOutput("after reset ready", 32'(rob_if.dispatch_ready), 32'd1);
        checkOutput("after reset commit_valid", 32'(rob_if.commit_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
